alu_result_pipe: RTL

Registered, handshaked result-select and writeback stage for the ALU datapath, the successor to the combinational result mux. Selects one of twelve functional-unit results by a 4-bit opcode, registers it with status flags, and presents it downstream over a valid/ready interface. It also sequences the multi-cycle divide/modulo unit: issues a start pulse, waits for done, and enforces a timeout. It sits between the functional units and the register-file writeback.

---
 rtl/alu_result_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_result_pipe.sv
// Registered result-select / writeback stage with valid/ready handshake.
// Also sequences the multi-cycle divide/modulo unit (start pulse, done wait, timeout).
module alu_result_pipe #(
    parameter int N           = 32,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      select,
    input  logic [12*N-1:0] r_bus,
    output logic            div_start,
    input  logic            div_done,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    result,
    output logic [3:0]      out_op,
    output logic            flag_zero,
    output logic            flag_neg,
    output logic            flag_illegal,
    output logic            flag_timeout,
    output logic            busy
);

    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_DIV, FULL} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   result_q, result_d;
    logic [3:0]     out_op_q, out_op_d;
    logic           zero_q, zero_d, neg_q, neg_d;
    logic           illegal_q, illegal_d, timeout_q, timeout_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           div_start_q, div_start_d;
    logic           accept, is_div;
    logic [N-1:0]   cap_val;

    // Opcodes 12-15 have no slot and fall through to zero.
    function automatic logic [N-1:0] pick(input logic [3:0] op, input logic [12*N-1:0] bus);
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < 12; k++)
            if (op == 4'(k)) v = bus[k*N +: N];
        return v;
    endfunction

    assign in_ready = !rst && (state_q == IDLE || (state_q == FULL && out_ready));
    assign accept   = in_valid && in_ready;
    assign is_div   = (select == 4'd5) || (select == 4'd11);

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_op_d    = out_op_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        div_start_d = 1'b0;
        cap_val     = '0;
        unique case (state_q)
            WAIT_DIV: begin
                // out_op_q holds the pending div/mod opcode while waiting.
                if (div_done) begin
                    cap_val   = pick(out_op_q, r_bus);
                    result_d  = cap_val;
                    zero_d    = (cap_val == '0);
                    neg_d     = cap_val[N-1];
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = FULL;
                end else if (cnt_q == CW'(DIV_TIMEOUT)) begin
                    result_d  = '0;
                    zero_d    = 1'b1;
                    neg_d     = 1'b0;
                    illegal_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = FULL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (state_q == FULL && out_ready) state_d = IDLE;
                if (accept) begin
                    out_op_d = select;
                    if (is_div) begin
                        cnt_d       = CW'(1);
                        div_start_d = 1'b1;
                        state_d     = WAIT_DIV;
                    end else begin
                        cap_val   = pick(select, r_bus);
                        result_d  = cap_val;
                        zero_d    = (cap_val == '0);
                        neg_d     = cap_val[N-1];
                        illegal_d = (select >= 4'd12);
                        timeout_d = 1'b0;
                        state_d   = FULL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            out_op_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_op_q    <= out_op_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            div_start_q <= div_start_d;
        end
    end

    assign out_valid    = (state_q == FULL);
    assign busy         = (state_q != IDLE);
    assign div_start    = div_start_q;
    assign result       = result_q;
    assign out_op       = out_op_q;
    assign flag_zero    = zero_q;
    assign flag_neg     = neg_q;
    assign flag_illegal = illegal_q;
    assign flag_timeout = timeout_q;

endmodule
